// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one synchronous memory port between two requesters
// (m0, m1). Each requester pulses a read strobe or a write mask for one
// cycle; the request is latched, issued to memory and completed with a
// one-cycle mX_rdone pulse (reads also update mX_rdata).
//
// Ports:
//   clk, resetn                  clock, synchronous active-low reset
//   mX_addr/wdata/wmask/rstrb    request inputs, X = 0,1 (sampled on strobe)
//   mX_rdata                     read data, held until the next mX read completes
//   mX_busy                      request pending or in flight
//   mX_rdone                     completion pulse (reads and writes)
//   mem_addr/rstrb/wmask/wdata   registered memory request
//   mem_rdata                    memory read data, valid MEM_LATENCY cycles after mem_rstrb
//
// Build option: MEM_ARB_FIXED_PRIO_EN -- m0 always wins a tie (m1 may starve).
// Undefined (default): round-robin between the two ports on a tie.
module mem_arbiter #(
    parameter int XLEN        = 32,
    parameter int MEM_LATENCY = 1
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [XLEN-1:0] m0_addr,
    input  logic            m0_rstrb,
    input  logic [3:0]      m0_wmask,
    input  logic [XLEN-1:0] m0_wdata,
    output logic [XLEN-1:0] m0_rdata,
    output logic            m0_busy,
    output logic            m0_rdone,
    input  logic [XLEN-1:0] m1_addr,
    input  logic            m1_rstrb,
    input  logic [3:0]      m1_wmask,
    input  logic [XLEN-1:0] m1_wdata,
    output logic [XLEN-1:0] m1_rdata,
    output logic            m1_busy,
    output logic            m1_rdone,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_rstrb,
    output logic [3:0]      mem_wmask,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    // Counter holds values 0..MEM_LATENCY-1.
    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t          state, state_d;
    logic [1:0]      pending;
    logic            gnt;          // port currently owning the memory
    logic [CW-1:0]   cnt;

    // Per-port request latches, index 0 = m0, 1 = m1.
    logic [1:0]      req;
    logic [XLEN-1:0] in_addr  [2];
    logic [XLEN-1:0] in_wdata [2];
    logic [3:0]      in_wmask [2];
    logic [XLEN-1:0] p_addr   [2];
    logic [XLEN-1:0] p_wdata  [2];
    logic [3:0]      p_wmask  [2];
    logic [1:0]      p_write;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic            last_grant;
`endif

    // FSM decode
    logic            do_grant;
    logic            grant_sel;
    logic            do_issue_end;
    logic            do_done;

    // A nonzero mask makes the request a write even if rstrb is also high.
    assign req[0]      = m0_rstrb | (|m0_wmask);
    assign req[1]      = m1_rstrb | (|m1_wmask);
    assign in_addr[0]  = m0_addr;
    assign in_addr[1]  = m1_addr;
    assign in_wdata[0] = m0_wdata;
    assign in_wdata[1] = m1_wdata;
    assign in_wmask[0] = m0_wmask;
    assign in_wmask[1] = m1_wmask;

    // busy is the pending flag itself: it drops in the same edge that raises rdone.
    assign m0_busy = pending[0];
    assign m1_busy = pending[1];

    always_comb begin
        state_d      = state;
        do_grant     = 1'b0;
        grant_sel    = 1'b0;
        do_issue_end = 1'b0;
        do_done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (|pending) begin
                    do_grant = 1'b1;
                    state_d  = S_ISSUE;
`ifdef MEM_ARB_FIXED_PRIO_EN
                    grant_sel = ~pending[0];
`else
                    grant_sel = (&pending) ? ~last_grant : pending[1];
`endif
                end
            end
            S_ISSUE: begin
                do_issue_end = 1'b1;
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    do_done = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= S_IDLE;
            pending   <= '0;
            gnt       <= 1'b0;
            cnt       <= '0;
            p_write   <= '0;
            for (int i = 0; i < 2; i++) begin
                p_addr[i]  <= '0;
                p_wdata[i] <= '0;
                p_wmask[i] <= '0;
            end
`ifndef MEM_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
            mem_addr  <= '0;
            mem_rstrb <= 1'b0;
            mem_wmask <= '0;
            mem_wdata <= '0;
            m0_rdata  <= '0;
            m1_rdata  <= '0;
            m0_rdone  <= 1'b0;
            m1_rdone  <= 1'b0;
        end else begin
            state <= state_d;

            // Capture; strobes while busy are dropped. A port is never both
            // capturing and completing in one cycle since completion needs pending.
            for (int i = 0; i < 2; i++) begin
                if (req[i] && !pending[i]) begin
                    pending[i] <= 1'b1;
                    p_addr[i]  <= in_addr[i];
                    p_wdata[i] <= in_wdata[i];
                    p_wmask[i] <= in_wmask[i];
                    p_write[i] <= |in_wmask[i];
                end
            end

            if (do_grant) begin
                gnt       <= grant_sel;
`ifndef MEM_ARB_FIXED_PRIO_EN
                last_grant <= grant_sel;
`endif
                mem_addr  <= p_addr[grant_sel];
                mem_wdata <= p_wdata[grant_sel];
                mem_rstrb <= ~p_write[grant_sel];
                mem_wmask <= p_write[grant_sel] ? p_wmask[grant_sel] : 4'b0000;
            end

            // Strobe lasts exactly the ISSUE cycle; addr/wdata stay put.
            if (do_issue_end) begin
                mem_rstrb <= 1'b0;
                mem_wmask <= 4'b0000;
                cnt       <= CW'(MEM_LATENCY - 1);
            end else if (state == S_WAIT && cnt != '0) begin
                cnt <= cnt - CW'(1);
            end

            m0_rdone <= do_done & ~gnt;
            m1_rdone <= do_done & gnt;
            if (do_done) begin
                pending[gnt] <= 1'b0;
                if (!p_write[gnt]) begin
                    if (gnt) m1_rdata <= mem_rdata;
                    else     m0_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        else
            n_pass++;
    endtask

    // ---------------- DUT with MEM_LATENCY=1 ----------------
    logic        resetn;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        m0_rstrb, m0_busy, m0_rdone, m1_rstrb, m1_busy, m1_rdone;
    logic [3:0]  m0_wmask, m1_wmask, mem_wmask;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_rstrb;

    mem_arbiter #(.XLEN(32), .MEM_LATENCY(1)) u_dut (
        .clk(clk), .resetn(resetn),
        .m0_addr(m0_addr), .m0_rstrb(m0_rstrb), .m0_wmask(m0_wmask), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_busy(m0_busy), .m0_rdone(m0_rdone),
        .m1_addr(m1_addr), .m1_rstrb(m1_rstrb), .m1_wmask(m1_wmask), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_busy(m1_busy), .m1_rdone(m1_rdone),
        .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // ---------------- DUT with MEM_LATENCY=3 ----------------
    logic        b_resetn;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata, b_m1_addr, b_m1_wdata, b_m1_rdata;
    logic        b_m0_rstrb, b_m0_busy, b_m0_rdone, b_m1_rstrb, b_m1_busy, b_m1_rdone;
    logic [3:0]  b_m0_wmask, b_m1_wmask, b_mem_wmask;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_mem_rstrb;

    mem_arbiter #(.XLEN(32), .MEM_LATENCY(3)) u_dut3 (
        .clk(clk), .resetn(b_resetn),
        .m0_addr(b_m0_addr), .m0_rstrb(b_m0_rstrb), .m0_wmask(b_m0_wmask), .m0_wdata(b_m0_wdata),
        .m0_rdata(b_m0_rdata), .m0_busy(b_m0_busy), .m0_rdone(b_m0_rdone),
        .m1_addr(b_m1_addr), .m1_rstrb(b_m1_rstrb), .m1_wmask(b_m1_wmask), .m1_wdata(b_m1_wdata),
        .m1_rdata(b_m1_rdata), .m1_busy(b_m1_busy), .m1_rdone(b_m1_rdone),
        .mem_addr(b_mem_addr), .mem_rstrb(b_mem_rstrb), .mem_wmask(b_mem_wmask),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // ---------------- memory models ----------------
    logic [31:0] mem  [256];
    logic [31:0] mem3 [256];
    logic [31:0] s1, s2;

    always @(posedge clk) begin
        if (mem_rstrb) mem_rdata <= mem[mem_addr[7:0]];
        for (int b = 0; b < 4; b++)
            if (mem_wmask[b]) mem[mem_addr[7:0]][b*8 +: 8] = mem_wdata[b*8 +: 8];
    end

    // Three-stage read pipe: data appears 3 cycles after the strobe cycle.
    always @(posedge clk) begin
        s1          <= b_mem_rstrb ? mem3[b_mem_addr[7:0]] : 32'h0;
        s2          <= s1;
        b_mem_rdata <= s2;
        for (int b = 0; b < 4; b++)
            if (b_mem_wmask[b]) mem3[b_mem_addr[7:0]][b*8 +: 8] = b_mem_wdata[b*8 +: 8];
    end

    // ---------------- scoreboard ----------------
    exp_t q0[$], q1[$], q3[$];
    exp_t e0, e1, e3;

    always @(negedge clk) begin
        if (m0_rdone) begin
            if (q0.size() == 0) chk("m0_unexpected_rdone", 64'(m0_rdone), 64'(0));
            else begin
                e0 = q0.pop_front();
                chk("m0_rdata", 64'(m0_rdata), 64'(e0.data));
                chk("m0_rdone_cycle", 64'(cyc), 64'(e0.cyc));
            end
        end
        if (m1_rdone) begin
            if (q1.size() == 0) chk("m1_unexpected_rdone", 64'(m1_rdone), 64'(0));
            else begin
                e1 = q1.pop_front();
                chk("m1_rdata", 64'(m1_rdata), 64'(e1.data));
                chk("m1_rdone_cycle", 64'(cyc), 64'(e1.cyc));
            end
        end
        if (b_m0_rdone) begin
            if (q3.size() == 0) chk("b_m0_unexpected_rdone", 64'(b_m0_rdone), 64'(0));
            else begin
                e3 = q3.pop_front();
                chk("b_m0_rdata", 64'(b_m0_rdata), 64'(e3.data));
                chk("b_m0_rdone_cycle", 64'(cyc), 64'(e3.cyc));
            end
        end
        if (b_m1_rdone) chk("b_m1_unexpected_rdone", 64'(b_m1_rdone), 64'(0));
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    int T;

    initial begin
        resetn = 1'b0; b_resetn = 1'b0;
        {m0_addr, m0_wdata, m0_rstrb, m0_wmask} = '0;
        {m1_addr, m1_wdata, m1_rstrb, m1_wmask} = '0;
        {b_m0_addr, b_m0_wdata, b_m0_rstrb, b_m0_wmask} = '0;
        {b_m1_addr, b_m1_wdata, b_m1_rstrb, b_m1_wmask} = '0;
        foreach (mem[i]) begin mem[i] = 32'h0; mem3[i] = 32'h0; end
        mem[8'h10] = 32'hDEADBEEF; mem[8'h20] = 32'h11223344;
        mem[8'h30] = 32'hA5A50030; mem[8'h40] = 32'h5A5A0040;
        mem3[8'h30] = 32'hA5A50030; mem3[8'h50] = 32'hCAFE0050;
        step(3);

        // Reset state
        chk("rst_m0_busy",   64'(m0_busy),   64'(0));
        chk("rst_m1_busy",   64'(m1_busy),   64'(0));
        chk("rst_mem_rstrb", 64'(mem_rstrb), 64'(0));
        chk("rst_mem_wmask", 64'(mem_wmask), 64'(0));
        chk("rst_mem_addr",  64'(mem_addr),  64'(0));
        chk("rst_m0_rdata",  64'(m0_rdata),  64'(0));
        chk("rst_b_rstrb",   64'(b_mem_rstrb), 64'(0));
        resetn = 1'b1; b_resetn = 1'b1;
        step(1);

        // Single read, latency 1
        T = cyc; m0_rstrb = 1'b1; m0_addr = 32'h10;
        q0.push_back('{data: 32'hDEADBEEF, cyc: T + 4});
        for (int k = 1; k <= 4; k++) begin
            step(1); m0_rstrb = 1'b0;
            chk($sformatf("rd_busy_c%0d", k), 64'(m0_busy), 64'(k <= 3));
            chk($sformatf("rd_mem_rstrb_c%0d", k), 64'(mem_rstrb), 64'(k == 2));
            if (k == 2) chk("rd_mem_addr", 64'(mem_addr), 64'(32'h10));
        end
        step(2);

        // Write: one-cycle mask, rdata untouched
        T = cyc; m1_wmask = 4'b0100; m1_addr = 32'h20; m1_wdata = 32'h00AB0000;
        q1.push_back('{data: 32'h0, cyc: T + 4});
        for (int k = 1; k <= 4; k++) begin
            step(1); m1_wmask = 4'b0;
            chk($sformatf("wr_mem_wmask_c%0d", k), 64'(mem_wmask), 64'((k == 2) ? 4'b0100 : 4'b0000));
            chk($sformatf("wr_mem_rstrb_c%0d", k), 64'(mem_rstrb), 64'(0));
        end
        chk("wr_mem_content", 64'(mem[8'h20]), 64'(32'h11AB3344));
        step(2);

        // Contention after m1 was last granted: m0 first
        T = cyc; m0_rstrb = 1'b1; m0_addr = 32'h30; m1_rstrb = 1'b1; m1_addr = 32'h40;
        q0.push_back('{data: 32'hA5A50030, cyc: T + 4});
        q1.push_back('{data: 32'h5A5A0040, cyc: T + 7});
        step(1); m0_rstrb = 1'b0; m1_rstrb = 1'b0;
        step(8);
        // m0 solo read, then contention again
        T = cyc; m0_rstrb = 1'b1; m0_addr = 32'h10;
        q0.push_back('{data: 32'hDEADBEEF, cyc: T + 4});
        step(1); m0_rstrb = 1'b0;
        step(5);
        T = cyc; m0_rstrb = 1'b1; m0_addr = 32'h30; m1_rstrb = 1'b1; m1_addr = 32'h40;
`ifdef MEM_ARB_FIXED_PRIO_EN
        q0.push_back('{data: 32'hA5A50030, cyc: T + 4});
        q1.push_back('{data: 32'h5A5A0040, cyc: T + 7});
`else
        q1.push_back('{data: 32'h5A5A0040, cyc: T + 4});
        q0.push_back('{data: 32'hA5A50030, cyc: T + 7});
`endif
        step(1); m0_rstrb = 1'b0; m1_rstrb = 1'b0;
        step(8);

        // Drop while busy, then re-strobe in the rdone cycle
        T = cyc; m0_rstrb = 1'b1; m0_addr = 32'h10;
        q0.push_back('{data: 32'hDEADBEEF, cyc: T + 4});
        step(1); m0_rstrb = 1'b0;
        step(1); m0_rstrb = 1'b1; m0_addr = 32'h30;
        step(1); m0_rstrb = 1'b0;
        step(1);
        chk("b2b_rdone_cycle", 64'(m0_rdone), 64'(1));
        m0_rstrb = 1'b1; m0_addr = 32'h40;
        q0.push_back('{data: 32'h5A5A0040, cyc: T + 8});
        step(1); m0_rstrb = 1'b0;
        step(6);

        // Reset during WAIT: no rdone, everything cleared
        T = cyc; m0_rstrb = 1'b1; m0_addr = 32'h10;
        step(1); m0_rstrb = 1'b0;
        step(2); resetn = 1'b0;
        step(1);
        chk("midrst_rdone", 64'(m0_rdone),  64'(0));
        chk("midrst_busy",  64'(m0_busy),   64'(0));
        chk("midrst_rstrb", 64'(mem_rstrb), 64'(0));
        chk("midrst_addr",  64'(mem_addr),  64'(0));
        chk("midrst_rdata", 64'(m0_rdata),  64'(0));
        resetn = 1'b1;
        step(2);
        T = cyc; m0_rstrb = 1'b1; m0_addr = 32'h10;
        q0.push_back('{data: 32'hDEADBEEF, cyc: T + 4});
        step(1); m0_rstrb = 1'b0;
        step(5);

        // MEM_LATENCY=3: rdone at T+6
        T = cyc; b_m0_rstrb = 1'b1; b_m0_addr = 32'h50;
        q3.push_back('{data: 32'hCAFE0050, cyc: T + 6});
        for (int k = 1; k <= 6; k++) begin
            step(1); b_m0_rstrb = 1'b0;
            chk($sformatf("l3_busy_c%0d", k), 64'(b_m0_busy), 64'(k <= 5));
            chk($sformatf("l3_rstrb_c%0d", k), 64'(b_mem_rstrb), 64'(k == 2));
        end
        step(2);
        // Reset during WAIT with latency 3
        T = cyc; b_m0_rstrb = 1'b1; b_m0_addr = 32'h30;
        step(1); b_m0_rstrb = 1'b0;
        step(3); b_resetn = 1'b0;
        step(1);
        chk("l3_midrst_busy",  64'(b_m0_busy),  64'(0));
        chk("l3_midrst_rdata", 64'(b_m0_rdata), 64'(0));
        chk("l3_midrst_addr",  64'(b_mem_addr), 64'(0));
        b_resetn = 1'b1;
        step(4);
        T = cyc; b_m0_rstrb = 1'b1; b_m0_addr = 32'h30;
        q3.push_back('{data: 32'hA5A50030, cyc: T + 6});
        step(1); b_m0_rstrb = 1'b0;
        step(8);

        chk("q0_drained", 64'(q0.size()), 64'(0));
        chk("q1_drained", 64'(q1.size()), 64'(0));
        chk("q3_drained", 64'(q3.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
